// File: rtl/io_resp.sv
// io_resp: I/O response block with a 4-deep TX FIFO, an RX holding register and STATUS.
// Optional OUTPORT register enabled by defining IO_RESP_GPO_EN.
module io_resp (
  input  logic        clk,
  input  logic        rst,
  input  logic        iom_in,
  input  logic        wen_in,
  input  logic [1:0]  addr_in,
  input  logic [15:0] wdata_in,
  output logic [15:0] rdata_out,
  output logic [15:0] tx_data_out,
  output logic        tx_valid_out,
  input  logic        tx_ready_in,
  input  logic [15:0] rx_data_in,
  input  logic        rx_valid_in,
  output logic        rx_ready_out,
  output logic [15:0] gpo_out
);

  typedef enum logic [1:0] {
    ADDR_TXDATA  = 2'd0,
    ADDR_RXDATA  = 2'd1,
    ADDR_STATUS  = 2'd2,
    ADDR_OUTPORT = 2'd3
  } io_addr_e;

  io_addr_e    addr;
  logic        wr_stb, rd_stb;
  logic        tx_push_req, tx_push, tx_pop;
  logic        rx_cap, rx_clr;
  logic [15:0] status;

  logic [15:0] mem_q [4];
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        tx_ovf_q, tx_ovf_d;
  logic        rx_full_q, rx_full_d;
  logic [15:0] rx_data_q, rx_data_d;

  assign addr   = io_addr_e'(addr_in);
  assign wr_stb = iom_in & ~wen_in;
  assign rd_stb = iom_in & wen_in;

  assign tx_valid_out = (cnt_q != 3'd0);
  assign tx_data_out  = mem_q[rd_ptr_q];
  assign rx_ready_out = ~rx_full_q;

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign tx_pop      = tx_valid_out & tx_ready_in;
  assign tx_push_req = wr_stb & (addr == ADDR_TXDATA);
  assign tx_push     = tx_push_req & ((cnt_q != 3'd4) | tx_pop);

  assign rx_cap = rx_valid_in & ~rx_full_q;
  assign rx_clr = rd_stb & (addr == ADDR_RXDATA) & rx_full_q;

  assign status = {9'd0, cnt_q, tx_ovf_q, rx_full_q, (cnt_q == 3'd0), (cnt_q == 3'd4)};

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    tx_ovf_d  = tx_ovf_q;
    rx_full_d = rx_full_q;
    rx_data_d = rx_data_q;

    if (tx_push) wr_ptr_d = wr_ptr_q + 2'd1;
    if (tx_pop)  rd_ptr_d = rd_ptr_q + 2'd1;
    case ({tx_push, tx_pop})
      2'b10:   cnt_d = cnt_q + 3'd1;
      2'b01:   cnt_d = cnt_q - 3'd1;
      default: cnt_d = cnt_q;
    endcase

    if (tx_push_req && !tx_push) tx_ovf_d = 1'b1;
    else if (wr_stb && addr == ADDR_STATUS && wdata_in[3]) tx_ovf_d = 1'b0;

    if (rx_cap) begin
      rx_full_d = 1'b1;
      rx_data_d = rx_data_in;
    end else if (rx_clr) begin
      rx_full_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= 2'd0;
      rd_ptr_q  <= 2'd0;
      cnt_q     <= 3'd0;
      tx_ovf_q  <= 1'b0;
      rx_full_q <= 1'b0;
      rx_data_q <= 16'd0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      tx_ovf_q  <= tx_ovf_d;
      rx_full_q <= rx_full_d;
      rx_data_q <= rx_data_d;
    end
  end

  // NOTE: FIFO storage is not reset; clearing the pointers and count already empties it.
  always_ff @(posedge clk) begin
    if (tx_push) mem_q[wr_ptr_q] <= wdata_in;
  end

`ifdef IO_RESP_GPO_EN
  logic [15:0] gpo_q, gpo_d;

  always_comb begin
    gpo_d = gpo_q;
    if (wr_stb && addr == ADDR_OUTPORT) gpo_d = wdata_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) gpo_q <= 16'd0;
    else     gpo_q <= gpo_d;
  end

  assign gpo_out = gpo_q;
`else
  assign gpo_out = 16'd0;
`endif

  always_comb begin
    rdata_out = 16'd0;
    if (rd_stb) begin
      case (addr)
        ADDR_TXDATA:  rdata_out = 16'd0;
        ADDR_RXDATA:  rdata_out = rx_data_q;
        ADDR_STATUS:  rdata_out = status;
        ADDR_OUTPORT: rdata_out = gpo_out;
        default:      rdata_out = 16'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_io_resp.sv
// Directed self-checking bench for io_resp; expected GPO values follow IO_RESP_GPO_EN.
module tb_io_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        iom_in, wen_in;
  logic [1:0]  addr_in;
  logic [15:0] wdata_in;
  logic [15:0] rdata_out;
  logic [15:0] tx_data_out;
  logic        tx_valid_out;
  logic        tx_ready_in;
  logic [15:0] rx_data_in;
  logic        rx_valid_in;
  logic        rx_ready_out;
  logic [15:0] gpo_out;

  int n_cmp = 0;
  int n_err = 0;

`ifdef IO_RESP_GPO_EN
  localparam logic [15:0] GPO_EXP = 16'h00FF;
`else
  localparam logic [15:0] GPO_EXP = 16'h0000;
`endif

  io_resp dut (
    .clk          (clk),
    .rst          (rst),
    .iom_in       (iom_in),
    .wen_in       (wen_in),
    .addr_in      (addr_in),
    .wdata_in     (wdata_in),
    .rdata_out    (rdata_out),
    .tx_data_out  (tx_data_out),
    .tx_valid_out (tx_valid_out),
    .tx_ready_in  (tx_ready_in),
    .rx_data_in   (rx_data_in),
    .rx_valid_in  (rx_valid_in),
    .rx_ready_out (rx_ready_out),
    .gpo_out      (gpo_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic io_write(input logic [1:0] a, input logic [15:0] d);
    iom_in = 1'b1; wen_in = 1'b0; addr_in = a; wdata_in = d;
    tick();
    iom_in = 1'b0; wen_in = 1'b1;
  endtask

  task automatic io_read(input string tag, input logic [1:0] a, input logic [15:0] exp);
    iom_in = 1'b1; wen_in = 1'b1; addr_in = a;
    #1;
    check(tag, rdata_out, exp);
    tick();
    iom_in = 1'b0;
  endtask

  initial begin
    rst = 1'b1; iom_in = 1'b0; wen_in = 1'b1; addr_in = 2'd0; wdata_in = 16'd0;
    tx_ready_in = 1'b0; rx_data_in = 16'd0; rx_valid_in = 1'b0;
    #12;
    check("rst_tx_valid", {15'd0, tx_valid_out}, 16'd0);
    check("rst_rx_ready", {15'd0, rx_ready_out}, 16'd1);
    check("rst_gpo", gpo_out, 16'h0000);
    check("rst_rdata", rdata_out, 16'h0000);
    tick();
    rst = 1'b0;
    tick();

    // Fill the FIFO with no downstream acceptance, then overflow it.
    io_write(2'd0, 16'h1111);
    check("first_push_valid", {15'd0, tx_valid_out}, 16'd1);
    check("first_push_head", tx_data_out, 16'h1111);
    io_write(2'd0, 16'h2222);
    io_write(2'd0, 16'h3333);
    io_write(2'd0, 16'h4444);
    io_read("status_full", 2'd2, 16'h0041);
    io_write(2'd0, 16'h5555);
    io_read("status_ovf", 2'd2, 16'h0049);
    check("ovf_head_kept", tx_data_out, 16'h1111);
    io_read("txdata_read_zero", 2'd0, 16'h0000);
    check("idle_rdata_zero", rdata_out, 16'h0000);

    // Drain in order.
    tx_ready_in = 1'b1;
    check("drain0", tx_data_out, 16'h1111); tick();
    check("drain1", tx_data_out, 16'h2222); tick();
    check("drain2", tx_data_out, 16'h3333); tick();
    check("drain3", tx_data_out, 16'h4444); tick();
    check("drained_valid", {15'd0, tx_valid_out}, 16'd0);
    tx_ready_in = 1'b0;
    io_read("status_empty_ovf", 2'd2, 16'h000A);
    io_write(2'd2, 16'h0008);
    io_read("status_ovf_clr", 2'd2, 16'h0002);

    // Full FIFO with pop and push in the same cycle.
    io_write(2'd0, 16'h0101);
    io_write(2'd0, 16'h0202);
    io_write(2'd0, 16'h0303);
    io_write(2'd0, 16'h0404);
    tx_ready_in = 1'b1;
    io_write(2'd0, 16'hAAAA);
    tx_ready_in = 1'b0;
    io_read("status_push_pop_full", 2'd2, 16'h0041);
    tx_ready_in = 1'b1;
    check("pp_drain0", tx_data_out, 16'h0202); tick();
    check("pp_drain1", tx_data_out, 16'h0303); tick();
    check("pp_drain2", tx_data_out, 16'h0404); tick();
    check("pp_drain3", tx_data_out, 16'hAAAA); tick();
    check("pp_drained_valid", {15'd0, tx_valid_out}, 16'd0);
    tx_ready_in = 1'b0;

    // RX capture, hold-off and release.
    rx_valid_in = 1'b1; rx_data_in = 16'hBEEF;
    tick();
    check("rx_full_ready", {15'd0, rx_ready_out}, 16'd0);
    rx_data_in = 16'hCAFE;
    tick();
    io_write(2'd1, 16'h1234);
    io_read("status_rx_full", 2'd2, 16'h0006);
    io_read("rx_first", 2'd1, 16'hBEEF);
    check("rx_cleared_ready", {15'd0, rx_ready_out}, 16'd1);
    tick();
    rx_valid_in = 1'b0;
    check("rx_second_held", {15'd0, rx_ready_out}, 16'd0);
    io_read("rx_second", 2'd1, 16'hCAFE);
    io_read("rx_stale", 2'd1, 16'hCAFE);
    io_read("status_rx_empty", 2'd2, 16'h0002);

    // OUTPORT.
    io_write(2'd3, 16'h00FF);
    check("gpo_out", gpo_out, GPO_EXP);
    io_read("gpo_read", 2'd3, GPO_EXP);

    // Asynchronous reset in the middle of a cycle with three entries queued.
    io_write(2'd0, 16'h0A0A);
    io_write(2'd0, 16'h0B0B);
    io_write(2'd0, 16'h0C0C);
    io_read("status_cnt3", 2'd2, 16'h0030);
    rx_valid_in = 1'b1; rx_data_in = 16'h7777;
    tick();
    rx_valid_in = 1'b0;
    rst = 1'b1;
    #1;
    check("arst_tx_valid", {15'd0, tx_valid_out}, 16'd0);
    check("arst_rx_ready", {15'd0, rx_ready_out}, 16'd1);
    check("arst_gpo", gpo_out, 16'h0000);
    iom_in = 1'b1; wen_in = 1'b1; addr_in = 2'd2;
    #1;
    check("arst_status", rdata_out, 16'h0002);
    iom_in = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    io_read("post_rst_status", 2'd2, 16'h0002);
    io_read("post_rst_rx", 2'd1, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/io_resp.md
IO_RESP -- requirements
Module: io_resp

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-high reset; ports SHALL be exactly as listed below.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 iom_in  in  1  I/O access qualifier from the control unit; an access occurs in every cycle it is 1.
REQ-005 wen_in  in  1  active-low write: 0 = write (IOW), 1 = read (IOR); ignored when iom_in=0.
REQ-006 addr_in  in  2  register select: 0 TXDATA, 1 RXDATA, 2 STATUS, 3 OUTPORT.
REQ-007 wdata_in  in  16  write data.
REQ-008 rdata_out  out  16  read data, combinational from registered state, valid in the access cycle.
REQ-009 tx_data_out  out  16  head entry of TX FIFO.
REQ-010 tx_valid_out  out  1  TX FIFO non-empty.
REQ-011 tx_ready_in  in  1  downstream accepts tx_data_out.
REQ-012 rx_data_in  in  16  upstream data.
REQ-013 rx_valid_in  in  1  upstream data valid.
REQ-014 rx_ready_out  out  1  RX holding register empty.
REQ-015 gpo_out  out  16  general-purpose output register.

Function
REQ-016 Write strobe = iom_in & ~wen_in; read strobe = iom_in & wen_in; all side effects take place at the clock edge ending the access cycle.
REQ-017 TX FIFO: 4 entries x 16 bits, 2-bit wrapping read/write pointers, 3-bit count 0..4.
REQ-018 Write to TXDATA pushes wdata_in when count<4, or when count=4 and a pop occurs in the same cycle (count stays 4).
REQ-019 Write to TXDATA when count=4 and no same-cycle pop SHALL drop the data, leave the FIFO unchanged, and set sticky tx_ovf.
REQ-020 Pop occurs when tx_valid_out & tx_ready_in; tx_valid_out = (count!=0); tx_data_out SHALL be the entry at the read pointer.
REQ-021 Simultaneous push and pop when count=0 is impossible (valid=0); when 0<count<4, both SHALL occur and count SHALL be unchanged.
REQ-022 RX: capture rx_data_in into the holding register and set rx_full when rx_valid_in & rx_ready_out; rx_ready_out = ~rx_full.
REQ-023 Read of RXDATA SHALL return the holding register and clear rx_full at the edge; a read when rx_full=0 SHALL return the stale value with no side effect.
REQ-024 STATUS read: bit0 tx_full (count=4), bit1 tx_empty (count=0), bit2 rx_full, bit3 tx_ovf, bits6:4 count, bits15:7 zero.
REQ-025 STATUS write with wdata_in[3]=1 SHALL clear tx_ovf; a simultaneous set condition is impossible (different address).
REQ-026 TXDATA read SHALL return 0 with no side effect; RXDATA and STATUS writes other than REQ-025 SHALL be ignored.
REQ-027 rdata_out SHALL be 0 in any cycle without a read strobe.
REQ-028 Latency: pushed data appears on tx_data_out the cycle after the write if FIFO was empty; captured RX data is readable the cycle after capture.

Reset
REQ-029 While rst=1: FIFO pointers and count 0, tx_ovf 0, rx_full 0, holding register 0, gpo 0; hence tx_valid_out=0, rx_ready_out=1, gpo_out=0, rdata_out=0.
REQ-030 Reset asserted mid-operation SHALL discard all FIFO contents and any pending RX word immediately, without waiting for a clock edge.

Configuration
REQ-031 Macro IO_RESP_GPO_EN: when defined, OUTPORT is a R/W register driving gpo_out (write loads wdata_in, read returns it).
REQ-032 When IO_RESP_GPO_EN is undefined, OUTPORT reads 0, writes are ignored, and gpo_out SHALL be constant 0.

Verification
REQ-033 After reset, write TXDATA 0x1111,0x2222,0x3333,0x4444 with tx_ready_in=0 -> STATUS=0x0041; fifth write 0x5555 -> STATUS=0x0049, FIFO still holds 0x1111..0x4444.
REQ-034 Then tx_ready_in=1 for 4 cycles -> tx_data_out 0x1111,0x2222,0x3333,0x4444 in order, then tx_valid_out=0; STATUS write 0x0008 -> STATUS=0x0002.
REQ-035 FIFO full, tx_ready_in=1 and TXDATA write 0xAAAA same cycle -> no ovf, count stays 4, 0xAAAA emerges fifth.
REQ-036 rx_valid_in=1, rx_data_in=0xBEEF -> rx_ready_out=0 next cycle, second word 0xCAFE held off; RXDATA read returns 0xBEEF, then 0xCAFE captured.
REQ-037 OUTPORT write 0x00FF -> gpo_out=0x00FF (0x0000 without IO_RESP_GPO_EN); assert rst mid-stream with FIFO count 3 -> tx_valid_out=0 and STATUS=0x0002 immediately.
